tone_period_meter: RTL and testbench
====================================

// Module: tone_period_meter
// PURPOSE
//  Receive side of the tone generators: measures the period of an external square wave on a pio pin.
//  Synchronises the pin, rejects glitch edges, averages 2**AVG_LOG2 periods, reports period in clock cycles.
//  Flags silence when no valid edge arrives within TIMEOUT_CYCLES.
//  Feeds note/pitch display logic in top; loopback-testable against frequency_generator.
// PARAMETERS
//  CLOCK_FREQUENCY    12000000  system clock, Hz (documentation / derived defaults)
//  CNT_WIDTH          20        period counter and output width; must hold TIMEOUT_CYCLES
//  MIN_PERIOD_CYCLES  600       shortest accepted period (20 kHz @ 12 MHz); shorter edges are glitches
//  TIMEOUT_CYCLES     600000    longest accepted period (20 Hz @ 12 MHz); beyond this = silence
//  AVG_LOG2           2         average over 2**AVG_LOG2 periods (0 = no averaging)
// PORTS
//  clock         in   1          system clock, all logic on posedge
//  reset_n       in   1          synchronous reset, active low
//  tone_in       in   1          asynchronous square-wave input from pio
//  period        out  CNT_WIDTH  averaged period in clock cycles; holds value between updates
//  period_valid  out  1          one-cycle pulse when period updates
//  present       out  1          1 = tone being measured, 0 = silence / not yet locked
//  timeout       out  1          one-cycle pulse on transition into silence
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): period=0, period_valid=0, present=0, timeout=0; sync regs, counter,
//   accumulator, sample count cleared; state=IDLE. Reset mid-operation discards partial average.
//  Sync: 2 FF chain + prev reg; rise = sync & ~prev. Pin edge -> rise seen 3 clocks later (fixed).
//  FSM IDLE: counter held 0; on rise -> MEASURE, counter<=0, no sample.
//  FSM MEASURE: counter increments every cycle. On rise, P = counter+1 = cycles since last accepted rise.
//   - P < MIN_PERIOD_CYCLES: edge ignored (glitch), counter keeps running, no reference update.
//   - else: accept; counter<=0; acc += P; sample count +1.
//   - on the 2**AVG_LOG2-th accepted sample: period <= (acc+P) >> AVG_LOG2 (truncate),
//     period_valid=1 next cycle, present<=1, acc and count cleared same cycle.
//  Timeout: counter == TIMEOUT_CYCLES-1 with no accepted rise that cycle -> IDLE, present<=0,
//   timeout pulse, acc/count cleared; period keeps last value. Accepted rise in that same cycle wins
//   (P = TIMEOUT_CYCLES is valid). Accepted range MIN_PERIOD_CYCLES..TIMEOUT_CYCLES inclusive.
//  Counter never wraps: timeout always precedes overflow. Accumulator width CNT_WIDTH+AVG_LOG2, no overflow.
//  period_valid and timeout never asserted in the same cycle.
//  Only rising edges are used; duty cycle is irrelevant.
// STRUCTURE
//  Shared package/include tone_pkg: CLOCK_FREQUENCY, cycles-per-Hz helpers, MIN/TIMEOUT defaults,
//   FSM state encoding (IDLE=0, MEASURE=1) shared with frequency_generator users.
//  Sub-module: edge_synchronizer (2-FF sync + rising-edge pulse, sync reset); rest in tone_period_meter.
// TESTING
//  1 Loopback frequency_generator(26163) -> tone_in: period_valid after 1+4 accepted rises,
//    period==45866, present=1; subsequent valid every 4*45866 cycles.
//  2 Glitch: tone_in low for 10 cycles, 100 cycles after an accepted rise -> edge rejected,
//    period stays 45866, no extra period_valid.
//  3 Stop tone after a rise -> timeout pulse exactly 600000 cycles after that accepted rise,
//    present=0, period holds 45866; restart -> needs 1+4 rises again.
//  4 Boundary: constant period 600 -> period==600; constant period 599 -> every other edge
//    rejected, period==1198.
//  5 Averaging: alternating periods 1000/1001 -> period==1000 (4002>>2, truncated).
//  6 reset_n low 1 cycle after 2 accepted samples -> all outputs 0 next cycle; next period_valid
//    only after fresh first rise + 4 periods, value unaffected by pre-reset samples.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator / tone meter family.
// Holds the default system clock, helpers that turn a tone frequency into a
// period in clock cycles, the default accepted period window and the FSM
// state encoding shared with the frequency_generator users.
package tone_pkg;

   localparam int DEFAULT_CLOCK_FREQUENCY = 12000000;
   localparam int MAX_TONE_HZ             = 20000;
   localparam int MIN_TONE_HZ             = 20;

   // Number of clock cycles in one period of a tone at toneHz.
   function automatic int cyclesPerHz(input int clockHz, input int toneHz);
      return clockHz / toneHz;
   endfunction

   // Tone frequency implied by a period measured in clock cycles.
   function automatic int hzFromCycles(input int clockHz, input int cycles);
      return (cycles == 0) ? 0 : clockHz / cycles;
   endfunction

   localparam int DEFAULT_MIN_PERIOD_CYCLES = cyclesPerHz(DEFAULT_CLOCK_FREQUENCY, MAX_TONE_HZ);
   localparam int DEFAULT_TIMEOUT_CYCLES    = cyclesPerHz(DEFAULT_CLOCK_FREQUENCY, MIN_TONE_HZ);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } tone_state_t;

endpackage

// File: rtl/edge_synchronizer.sv
// Brings an asynchronous pin into the clock domain through two flops and
// produces a one-cycle pulse on each synchronised rising edge.
module edge_synchronizer (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Two-stage synchroniser plus a delayed copy used for edge detection.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the period of an external square wave in clock cycles.
// Rising edges closer together than MIN_PERIOD_CYCLES are treated as glitches,
// 2**AVG_LOG2 accepted periods are averaged before each report, and a gap of
// TIMEOUT_CYCLES without an accepted edge drops the meter back to silence.
module tone_period_meter
   import tone_pkg::*;
#(
   parameter int CLOCK_FREQUENCY   = DEFAULT_CLOCK_FREQUENCY,
   parameter int CNT_WIDTH         = 20,
   parameter int MIN_PERIOD_CYCLES = cyclesPerHz(CLOCK_FREQUENCY, MAX_TONE_HZ),
   parameter int TIMEOUT_CYCLES    = cyclesPerHz(CLOCK_FREQUENCY, MIN_TONE_HZ),
   parameter int AVG_LOG2          = 2
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_tone_in,
   output logic [CNT_WIDTH-1:0] o_period,
   output logic                 o_period_valid,
   output logic                 o_present,
   output logic                 o_timeout
);

   localparam int ACC_WIDTH    = CNT_WIDTH + AVG_LOG2;
   localparam int SAMPLE_WIDTH = AVG_LOG2 + 1;

   localparam logic [CNT_WIDTH-1:0]    MIN_PERIOD  = CNT_WIDTH'(MIN_PERIOD_CYCLES);
   localparam logic [CNT_WIDTH-1:0]    LAST_COUNT  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [SAMPLE_WIDTH-1:0] LAST_SAMPLE = SAMPLE_WIDTH'((1 << AVG_LOG2) - 1);

   tone_state_t             r_state;
   logic [CNT_WIDTH-1:0]    r_count;
   logic [ACC_WIDTH-1:0]    r_acc;
   logic [SAMPLE_WIDTH-1:0] r_samples;
   logic [CNT_WIDTH-1:0]    r_period;
   logic                    r_period_valid;
   logic                    r_present;
   logic                    r_timeout;

   logic                    w_rise;
   logic [CNT_WIDTH-1:0]    w_sample;
   logic                    w_accept;
   logic [ACC_WIDTH-1:0]    w_sum;

   edge_synchronizer u_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_async   (i_tone_in),
      .o_rise    (w_rise)
   );

   // The counter restarts at zero on the accepted rise, so the number of cycles
   // since that rise is one more than the count seen at the next rise.
   assign w_sample = r_count + CNT_WIDTH'(1);
   assign w_accept = (r_state == MEASURE) && w_rise && (w_sample >= MIN_PERIOD);
   assign w_sum    = r_acc + ACC_WIDTH'(w_sample);

   // Measurement FSM: period counting, glitch rejection, averaging and silence detection.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state        <= IDLE;
         r_count        <= '0;
         r_acc          <= '0;
         r_samples      <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_present      <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_period_valid <= 1'b0;
         r_timeout      <= 1'b0;
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (w_rise) begin
                  r_state <= MEASURE;
               end
            end
            MEASURE: begin
               if (w_accept) begin
                  r_count <= '0;
                  if (r_samples == LAST_SAMPLE) begin
                     r_period       <= CNT_WIDTH'(w_sum >> AVG_LOG2);
                     r_period_valid <= 1'b1;
                     r_present      <= 1'b1;
                     r_acc          <= '0;
                     r_samples      <= '0;
                  end else begin
                     r_acc     <= w_sum;
                     r_samples <= r_samples + SAMPLE_WIDTH'(1);
                  end
               end else if (r_count == LAST_COUNT) begin
                  r_state   <= IDLE;
                  r_count   <= '0;
                  r_present <= 1'b0;
                  r_timeout <= 1'b1;
                  r_acc     <= '0;
                  r_samples <= '0;
               end else begin
                  r_count <= r_count + CNT_WIDTH'(1);
               end
            end
         endcase
      end
   end

   assign o_period       = r_period;
   assign o_period_valid = r_period_valid;
   assign o_present      = r_present;
   assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter with scaled-down period limits so
// timeouts and several averaging windows fit in a short run. Expected periods
// are queued as the tone is driven and popped when the meter reports.
module tb_tone_period_meter;

   localparam int CNT_WIDTH    = 16;
   localparam int MIN_PERIOD   = 60;
   localparam int TIMEOUT      = 3000;
   localparam int AVG_LOG2     = 2;
   localparam int SYNC_LATENCY = 3;
   localparam int TONE_PERIOD  = 457;

   logic                 clock   = 1'b0;
   logic                 resetN  = 1'b0;
   logic                 toneIn  = 1'b0;
   logic [CNT_WIDTH-1:0] period;
   logic                 periodValid;
   logic                 present;
   logic                 timeoutPulse;

   int assertions     = 0;
   int failures       = 0;
   int cycle          = 0;
   int validCount     = 0;
   int timeoutCount   = 0;
   int lastValidCycle = 0;
   int prevValidCycle = 0;
   int lastRiseCycle  = 0;
   int expPeriod      = 0;
   int expectedPeriods[$];

   tone_period_meter #(
      .CNT_WIDTH         (CNT_WIDTH),
      .MIN_PERIOD_CYCLES (MIN_PERIOD),
      .TIMEOUT_CYCLES    (TIMEOUT),
      .AVG_LOG2          (AVG_LOG2)
   ) dut (
      .i_clock        (clock),
      .i_reset_n      (resetN),
      .i_tone_in      (toneIn),
      .o_period       (period),
      .o_period_valid (periodValid),
      .o_present      (present),
      .o_timeout      (timeoutPulse)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Cycle stamp used to measure latencies and intervals.
   always @(posedge clock) cycle++;

   // Scoreboard: every period report is checked against the oldest queued value.
   always @(negedge clock) begin
      if (periodValid === 1'b1) begin
         validCount++;
         prevValidCycle = lastValidCycle;
         lastValidCycle = cycle;
         assertions++;
         if (expectedPeriods.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_period_valid: period=%0d but no report was expected", period);
         end else begin
            expPeriod = expectedPeriods.pop_front();
            if (period !== CNT_WIDTH'(expPeriod)) begin
               failures++;
               $display("[TB] FAIL period_report: got %0d, expected %0d", period, expPeriod);
            end
         end
      end
      if (timeoutPulse === 1'b1) timeoutCount++;
      if (periodValid === 1'b1 || timeoutPulse === 1'b1) begin
         assertions++;
         if (periodValid === 1'b1 && timeoutPulse === 1'b1) begin
            failures++;
            $display("[TB] FAIL valid_and_timeout: both asserted in one cycle, required exclusive");
         end
      end
   end

   // Drives count rising edges, each followed by highCycles high and lowCycles low.
   task automatic applyStimulus(input int highCycles, input int lowCycles, input int count);
      for (int i = 0; i < count; i++) begin
         @(negedge clock);
         toneIn = 1'b1;
         lastRiseCycle = cycle;
         repeat (highCycles) @(negedge clock);
         toneIn = 1'b0;
         repeat (lowCycles - 1) @(negedge clock);
      end
   endtask

   task automatic doReset();
      @(negedge clock);
      resetN = 1'b0;
      toneIn = 1'b0;
      repeat (3) @(negedge clock);
      resetN = 1'b1;
   endtask

   task automatic checkQueueDrained(input string name);
      assertions++;
      if (expectedPeriods.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s_pending: %0d reports outstanding, expected 0", name, expectedPeriods.size());
         expectedPeriods.delete();
      end
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      toneIn = 1'b0;
      repeat (3) @(negedge clock);
      assertions++;
      if (period !== '0) begin failures++; $display("[TB] FAIL reset_period: got %0d, expected 0", period); end
      assertions++;
      if (periodValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, expected 0", periodValid); end
      assertions++;
      if (present !== 1'b0) begin failures++; $display("[TB] FAIL reset_present: got %b, expected 0", present); end
      assertions++;
      if (timeoutPulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b, expected 0", timeoutPulse); end
      resetN = 1'b1;
   endtask

   task automatic test_loopback();
      int startValid;
      startValid = validCount;
      expectedPeriods.push_back(TONE_PERIOD);
      expectedPeriods.push_back(TONE_PERIOD);
      applyStimulus(TONE_PERIOD / 2, TONE_PERIOD - TONE_PERIOD / 2, 9);
      assertions++;
      if (validCount - startValid != 2) begin
         failures++;
         $display("[TB] FAIL loopback_reports: got %0d, expected 2", validCount - startValid);
      end
      assertions++;
      if (lastValidCycle - prevValidCycle != 4 * TONE_PERIOD) begin
         failures++;
         $display("[TB] FAIL loopback_interval: got %0d, expected %0d", lastValidCycle - prevValidCycle, 4 * TONE_PERIOD);
      end
      assertions++;
      if (present !== 1'b1) begin failures++; $display("[TB] FAIL loopback_present: got %b, expected 1", present); end
      checkQueueDrained("loopback");
   endtask

   task automatic test_glitch();
      int startValid;
      startValid = validCount;
      @(negedge clock);
      toneIn = 1'b1;
      repeat (20) @(negedge clock);
      toneIn = 1'b0;
      repeat (10) @(negedge clock);
      toneIn = 1'b1;
      repeat (200) @(negedge clock);
      toneIn = 1'b0;
      repeat (TONE_PERIOD - 230 - 1) @(negedge clock);
      expectedPeriods.push_back(TONE_PERIOD);
      applyStimulus(TONE_PERIOD / 2, TONE_PERIOD - TONE_PERIOD / 2, 3);
      assertions++;
      if (validCount - startValid != 1) begin
         failures++;
         $display("[TB] FAIL glitch_reports: got %0d, expected 1", validCount - startValid);
      end
      assertions++;
      if (period !== CNT_WIDTH'(TONE_PERIOD)) begin
         failures++;
         $display("[TB] FAIL glitch_period: got %0d, expected %0d", period, TONE_PERIOD);
      end
      checkQueueDrained("glitch");
   endtask

   task automatic test_timeout();
      int startValid;
      int startTimeouts;
      int seenCycle;
      bit found;
      startTimeouts = timeoutCount;
      found = 1'b0;
      seenCycle = 0;
      applyStimulus(100, 1, 1);
      for (int i = 0; i < TIMEOUT + 100 && !found; i++) begin
         @(negedge clock);
         if (timeoutPulse === 1'b1) begin
            found = 1'b1;
            seenCycle = cycle;
         end
      end
      assertions++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL timeout_missing: no pulse within %0d cycles", TIMEOUT + 100);
      end else if (seenCycle - lastRiseCycle != TIMEOUT + SYNC_LATENCY) begin
         failures++;
         $display("[TB] FAIL timeout_latency: got %0d, expected %0d", seenCycle - lastRiseCycle, TIMEOUT + SYNC_LATENCY);
      end
      assertions++;
      if (present !== 1'b0) begin failures++; $display("[TB] FAIL timeout_present: got %b, expected 0", present); end
      assertions++;
      if (period !== CNT_WIDTH'(TONE_PERIOD)) begin
         failures++;
         $display("[TB] FAIL timeout_hold: got %0d, expected %0d", period, TONE_PERIOD);
      end
      @(negedge clock);
      assertions++;
      if (timeoutCount - startTimeouts != 1) begin
         failures++;
         $display("[TB] FAIL timeout_count: got %0d, expected 1", timeoutCount - startTimeouts);
      end
      startValid = validCount;
      applyStimulus(250, 250, 4);
      assertions++;
      if (validCount != startValid) begin
         failures++;
         $display("[TB] FAIL restart_early: got %0d reports, expected 0", validCount - startValid);
      end
      expectedPeriods.push_back(500);
      applyStimulus(250, 250, 1);
      assertions++;
      if (validCount - startValid != 1) begin
         failures++;
         $display("[TB] FAIL restart_report: got %0d, expected 1", validCount - startValid);
      end
      checkQueueDrained("timeout");
   endtask

   task automatic test_boundary();
      int startValid;
      int startTimeouts;
      doReset();
      startValid = validCount;
      expectedPeriods.push_back(MIN_PERIOD);
      applyStimulus(MIN_PERIOD / 2, MIN_PERIOD - MIN_PERIOD / 2, 5);
      assertions++;
      if (period !== CNT_WIDTH'(MIN_PERIOD) || validCount - startValid != 1) begin
         failures++;
         $display("[TB] FAIL min_period: got %0d (%0d reports), expected %0d (1 report)", period, validCount - startValid, MIN_PERIOD);
      end
      doReset();
      startValid = validCount;
      expectedPeriods.push_back(2 * (MIN_PERIOD - 1));
      applyStimulus(30, MIN_PERIOD - 1 - 30, 9);
      assertions++;
      if (period !== CNT_WIDTH'(2 * (MIN_PERIOD - 1)) || validCount - startValid != 1) begin
         failures++;
         $display("[TB] FAIL below_min: got %0d (%0d reports), expected %0d (1 report)", period, validCount - startValid, 2 * (MIN_PERIOD - 1));
      end
      doReset();
      startValid = validCount;
      startTimeouts = timeoutCount;
      expectedPeriods.push_back(TIMEOUT);
      applyStimulus(TIMEOUT / 2, TIMEOUT - TIMEOUT / 2, 5);
      assertions++;
      if (period !== CNT_WIDTH'(TIMEOUT) || validCount - startValid != 1) begin
         failures++;
         $display("[TB] FAIL max_period: got %0d (%0d reports), expected %0d (1 report)", period, validCount - startValid, TIMEOUT);
      end
      assertions++;
      if (timeoutCount != startTimeouts) begin
         failures++;
         $display("[TB] FAIL max_period_timeout: got %0d pulses, expected 0", timeoutCount - startTimeouts);
      end
      checkQueueDrained("boundary");
   endtask

   task automatic test_averaging();
      int sum;
      int lowCycles;
      sum = 0;
      doReset();
      for (int i = 0; i < 4; i++) sum += (i % 2 == 0) ? 1000 : 1001;
      expectedPeriods.push_back(sum >> AVG_LOG2);
      for (int i = 0; i < 5; i++) begin
         lowCycles = (i % 2 == 0) ? 500 : 501;
         applyStimulus(500, lowCycles, 1);
      end
      assertions++;
      if (period !== CNT_WIDTH'(sum >> AVG_LOG2)) begin
         failures++;
         $display("[TB] FAIL averaging: got %0d, expected %0d", period, sum >> AVG_LOG2);
      end
      checkQueueDrained("averaging");
   endtask

   task automatic test_reset_midop();
      int startValid;
      applyStimulus(400, 400, 3);
      @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      assertions++;
      if (period !== '0 || periodValid !== 1'b0 || present !== 1'b0 || timeoutPulse !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midop_reset: got period=%0d valid=%b present=%b timeout=%b, expected all 0",
                  period, periodValid, present, timeoutPulse);
      end
      resetN = 1'b1;
      startValid = validCount;
      applyStimulus(350, 350, 4);
      assertions++;
      if (validCount != startValid) begin
         failures++;
         $display("[TB] FAIL midop_early: got %0d reports, expected 0", validCount - startValid);
      end
      expectedPeriods.push_back(700);
      applyStimulus(350, 350, 1);
      assertions++;
      if (period !== CNT_WIDTH'(700) || present !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midop_fresh: got period=%0d present=%b, expected 700 and 1", period, present);
      end
      checkQueueDrained("midop");
   endtask

   initial begin
      $display("[TB] tone_period_meter bench starting");
      test_reset();
      test_loopback();
      test_glitch();
      test_timeout();
      test_boundary();
      test_averaging();
      test_reset_midop();
      repeat (5) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
